inst_prefetch_queue: RTL

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of `pipelined_cpu`. It runs its own fetch PC and issues word reads to instruction memory over a req/ready handshake. It buffers up to DEPTH fetched instructions with their PCs and presents them to the IF stage over a valid/ready handshake. A redirect from a taken branch or jump flushes the queue and restarts fetching at the new PC, and any read still in flight is discarded.

---
 rtl/inst_prefetch_queue.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Purpose  : Instruction prefetch queue sitting between instruction memory
//            and the IF/ID register. Runs its own fetch PC, issues word reads
//            over a req/ready handshake, buffers up to DEPTH {pc, inst}
//            pairs and presents the oldest one to the IF stage over a
//            valid/ready handshake. A redirect flushes the queue, restarts
//            fetching at the new PC and discards any read still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH      queue entries (power of two, >= 2)
//   ADDR_LEN   PC / address width
//   INSTR_LEN  instruction width
//   RESET_PC   fetch PC after reset
// Ports
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   mem_req_o         instruction read request
//   mem_addr_o        word-aligned read address, stable until mem_ready_i
//   mem_ready_i       read completes this cycle, mem_rdata_i valid
//   mem_rdata_i       instruction read data
//   out_valid_o       queue head valid
//   out_ready_i       IF stage accepts the head (low = stall)
//   out_inst_o        head instruction
//   out_pc_o          head instruction address
//   out_pc_plus_4_o   out_pc_o + 4
//   redirect_valid_i  taken branch / jump, flush and refetch
//   redirect_pc_i     new fetch PC (low two bits ignored)
// ============================================================================
module inst_prefetch_queue #(
  parameter int                  DEPTH     = 4,
  parameter int                  ADDR_LEN  = 32,
  parameter int                  INSTR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction memory side
  output logic                 mem_req_o,
  output logic [ADDR_LEN-1:0]  mem_addr_o,
  input  logic                 mem_ready_i,
  input  logic [INSTR_LEN-1:0] mem_rdata_i,
  // IF stage side
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [INSTR_LEN-1:0] out_inst_o,
  output logic [ADDR_LEN-1:0]  out_pc_o,
  output logic [ADDR_LEN-1:0]  out_pc_plus_4_o,
  // redirect from branch / jump resolution
  input  logic                 redirect_valid_i,
  input  logic [ADDR_LEN-1:0]  redirect_pc_i
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_LEN-1:0] WORD_STEP = ADDR_LEN'(4);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;  // no read outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // read outstanding, result kept
  localparam logic [1:0] S_DROP = 2'd2;  // read outstanding, result discarded

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]           state_q,    state_d;
  logic [ADDR_LEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_LEN-1:0]  req_addr_q, req_addr_d;
  logic [PTR_W-1:0]     head_q,     head_d;
  logic [PTR_W-1:0]     tail_q,     tail_d;
  logic [CNT_W-1:0]     count_q,    count_d;

  logic [ADDR_LEN-1:0]  pc_mem_q   [DEPTH];
  logic [INSTR_LEN-1:0] inst_mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_busy;
  logic [CNT_W:0]      w_occupancy;
  logic                w_can_issue;
  logic                w_mem_req;
  logic [ADDR_LEN-1:0] w_mem_addr;
  logic                w_push;
  logic                w_pop;
  logic                w_out_valid;
  logic [ADDR_LEN-1:0] w_redirect_aligned;
  logic                w_unused_low_bits;

  assign w_busy = (state_q != S_IDLE);

  // An outstanding read reserves a slot so its data always has a home.
  // A pop in the same cycle does not free a slot for issuing.
  assign w_occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, w_busy};
  assign w_can_issue = (w_occupancy < DEPTH_LIM);

  assign w_out_valid        = (count_q != '0);
  assign w_pop              = w_out_valid & out_ready_i & ~redirect_valid_i;
  assign w_redirect_aligned = {redirect_pc_i[ADDR_LEN-1:2], 2'b00};

  // The low address bits of a redirect target are intentionally dropped.
  assign w_unused_low_bits = ^redirect_pc_i[1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_mem_req && !mem_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completing read returns to IDLE whether its data is kept or
        // discarded; only a redirect without completion needs DROP.
        if (mem_ready_i) begin
          state_d = S_IDLE;
        end else if (redirect_valid_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (memory request, address, push qualification)
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_req  = 1'b0;
    w_mem_addr = fetch_pc_q;
    w_push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // No new request in a redirect cycle: fetch_pc is about to change.
        w_mem_req  = w_can_issue & ~redirect_valid_i;
        w_mem_addr = fetch_pc_q;
        w_push     = w_mem_req & mem_ready_i;
      end
      S_WAIT: begin
        w_mem_req  = 1'b1;
        w_mem_addr = req_addr_q;
        w_push     = mem_ready_i & ~redirect_valid_i;
      end
      S_DROP: begin
        w_mem_req  = 1'b1;
        w_mem_addr = req_addr_q;
        w_push     = 1'b0;
      end
      default: begin
        w_mem_req  = 1'b0;
        w_mem_addr = fetch_pc_q;
        w_push     = 1'b0;
      end
    endcase
    // A read abandoned by reset must not be requested during the reset cycle.
    if (rst) begin
      w_mem_req = 1'b0;
      w_push    = 1'b0;
    end
  end

  assign mem_req_o  = w_mem_req;
  assign mem_addr_o = w_mem_addr;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    // Latch the address of a request that did not complete immediately so
    // it stays stable until the memory acknowledges it.
    if ((state_q == S_IDLE) && w_mem_req && !mem_ready_i) begin
      req_addr_d = fetch_pc_q;
    end

    if (redirect_valid_i) begin
      fetch_pc_d = w_redirect_aligned;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = fetch_pc_q + WORD_STEP;
        tail_d     = tail_q + PTR_W'(1);
      end
      if (w_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the head presents zeros afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      pc_mem_q[tail_q]   <= w_mem_addr;
      inst_mem_q[tail_q] <= mem_rdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // IF-stage outputs: driven straight from registers
  // --------------------------------------------------------------------------
  assign out_valid_o     = w_out_valid;
  assign out_inst_o      = inst_mem_q[head_q];
  assign out_pc_o        = pc_mem_q[head_q];
  assign out_pc_plus_4_o = pc_mem_q[head_q] + WORD_STEP;

endmodule
`default_nettype wire
